// File: rtl/rgb_pattern_pkg.sv
// rtl/rgb_pattern_pkg.sv - shared types and default VGA timing for the RGB pattern generator
package rgb_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/video_timing_counter.sv
// rtl/video_timing_counter.sv - raster position counters with registered sync/vde flags
module video_timing_counter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          idle_i,
  input  logic          advance_i,
  output logic [HW-1:0] h_next_o,
  output logic [VW-1:0] v_next_o,
  output logic          vde_next_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          vde_o,
  output logic          frame_end_o
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          vde_q, vde_d;

  // next raster position; idle parks the counters at (0,0) with all flags low
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (idle_i) begin
      h_d = '0;
      v_d = '0;
    end else if (advance_i) begin
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    vde_d   = ~idle_i & (h_d < HW'(H_ACTIVE)) & (v_d < VW'(V_ACTIVE));
    hsync_d = ~idle_i & (h_d >= HW'(H_ACTIVE + H_FP)) & (h_d <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
    vsync_d = ~idle_i & (v_d >= VW'(V_ACTIVE + V_FP)) & (v_d <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
  end

  // position and flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      vde_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vde_q   <= vde_d;
    end
  end

  assign h_next_o    = h_d;
  assign v_next_o    = v_d;
  assign vde_next_o  = vde_d;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign vde_o       = vde_q;
  assign frame_end_o = (h_q == HW'(H_TOTAL - 1)) & (v_q == VW'(V_TOTAL - 1));

endmodule

// File: rtl/rgb_pattern_gen.sv
// rtl/rgb_pattern_gen.sv - frame-based RGB test pattern source with valid/ready handshake
module rgb_pattern_gen
  import rgb_pattern_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [1:0]  pattern_i,
  input  logic [23:0] color_i,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        vde_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        sof_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int PW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  state_e        state_q, state_d;
  pattern_e      pat_q, pat_d;
  logic [23:0]   col_q, col_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          sof_q, sof_d;
  logic          valid_q, valid_d;

  logic          idle, advance, frame_end, vde_next, chk;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic [7:0]    h8;

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .idle_i     (idle),
    .advance_i  (advance),
    .h_next_o   (h_next),
    .v_next_o   (v_next),
    .vde_next_o (vde_next),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .vde_o      (vde_o),
    .frame_end_o(frame_end)
  );

  // frame FSM: start/stop only at frame boundaries, step the raster on each handshake
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    col_d   = col_q;
    idle    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = RUN;
          pat_d   = pattern_e'(pattern_i);
          col_d   = color_i;
        end else begin
          idle = 1'b1;
        end
      end
      RUN: begin
        if (valid_q & ready_i) begin
          if (!frame_end) begin
            advance = 1'b1;
          end else if (enable_i) begin
            advance = 1'b1;
            pat_d   = pattern_e'(pattern_i);
            col_d   = color_i;
          end else begin
            state_d = IDLE;
            idle    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pixel for the upcoming beat, derived from the next raster position
  always_comb begin
    idx_d = idx_q;
    pix_d = pix_q;
    if (h_next == '0) begin
      idx_d = 3'd0;
      pix_d = '0;
    end else if (advance) begin
      if (pix_q == PW'(BAR_W - 1)) begin
        pix_d = '0;
        if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
      end else begin
        pix_d = pix_q + 1'b1;
      end
    end
    h8  = 8'(h_next);
    chk = h8[5] ^ 1'(16'(v_next) >> 5);
    case (pat_d)
      PAT_BARS:  rgb_d = {{8{~idx_d[1]}}, {8{~idx_d[2]}}, {8{~idx_d[0]}}};
      PAT_GRAD:  rgb_d = {h8, h8, h8};
      PAT_CHECK: rgb_d = chk ? 24'h000000 : 24'hFFFFFF;
      PAT_SOLID: rgb_d = col_d;
      default:   rgb_d = 24'h000000;
    endcase
    if (!vde_next) rgb_d = 24'h000000;
    valid_d = (state_d == RUN);
    sof_d   = valid_d & (h_next == '0) & (v_next == '0);
  end

  // state, latches and registered beat outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pat_q   <= PAT_BARS;
      col_q   <= 24'h000000;
      idx_q   <= 3'd0;
      pix_q   <= '0;
      rgb_q   <= 24'h000000;
      sof_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      rgb_q   <= rgb_d;
      sof_q   <= sof_d;
      valid_q <= valid_d;
    end
  end

  assign r_o     = rgb_q[23:16];
  assign g_o     = rgb_q[15:8];
  assign b_o     = rgb_q[7:0];
  assign sof_o   = sof_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_rgb_pattern_gen.sv
// tb/tb_rgb_pattern_gen.sv - scoreboard bench for rgb_pattern_gen
module tb_rgb_pattern_gen;

  localparam int SHA = 8;
  localparam int SHT = 14;
  localparam int SVA = 4;
  localparam int SVT = 7;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic [1:0]  pattern_i = 2'd0;
  logic [23:0] color_i = 24'h0;
  logic        ready_i = 1'b1;
  logic [7:0]  r_o, g_o, b_o;
  logic        hsync_o, vsync_o, vde_o, valid_o, sof_o;

  logic        v_enable = 1'b0;
  logic [1:0]  v_pattern = 2'd2;
  logic [23:0] v_color = 24'h0;
  logic        v_ready = 1'b1;
  logic [7:0]  v_r, v_g, v_b;
  logic        v_hsync, v_vsync, v_vde, v_valid, v_sof;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs0;
  int vidx = 0;
  int vga_hits = 0;
  bit rand_rdy = 1'b0;
  logic [28:0] sb[$];

  always #5 clk = ~clk;

  rgb_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .pattern_i(pattern_i),
    .color_i(color_i), .r_o(r_o), .g_o(g_o), .b_o(b_o), .hsync_o(hsync_o),
    .vsync_o(vsync_o), .vde_o(vde_o), .valid_o(valid_o), .ready_i(ready_i), .sof_o(sof_o)
  );

  rgb_pattern_gen dut_vga (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(v_enable), .pattern_i(v_pattern),
    .color_i(v_color), .r_o(v_r), .g_o(v_g), .b_o(v_b), .hsync_o(v_hsync),
    .vsync_o(v_vsync), .vde_o(v_vde), .valid_o(v_valid), .ready_i(v_ready), .sof_o(v_sof)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] exp_beat(input int h, input int v, input int pat, input logic [23:0] col);
    logic [23:0] bars [8];
    logic [23:0] rgb;
    logic vde, hs, vs, sof;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    vde = (h < SHA) && (v < SVA);
    hs  = (h >= 10) && (h <= 11);
    vs  = (v == 5);
    sof = (h == 0) && (v == 0);
    case (pat)
      0:       rgb = bars[(h > 7) ? 7 : h];
      1:       rgb = {3{8'(h)}};
      2:       rgb = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      default: rgb = col;
    endcase
    if (!vde) rgb = 24'h0;
    return {1'b1, sof, vde, hs, vs, rgb};
  endfunction

  task automatic push_frame(input int pat, input logic [23:0] col);
    for (int v = 0; v < SVT; v++)
      for (int h = 0; h < SHT; h++)
        sb.push_back(exp_beat(h, v, pat, col));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || valid_o) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_queue", sb.size(), 0);
    check_eq("drain_valid", {31'd0, valid_o}, 0);
  endtask

  // small-raster monitor: scoreboard pop on handshake, hold check on stall
  initial begin
    logic [28:0] word, stall_word;
    bit stall_q;
    stall_q = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        stall_q = 1'b0;
      end else begin
        word = {valid_o, sof_o, vde_o, hsync_o, vsync_o, r_o, g_o, b_o};
        if (stall_q) check_eq("stall_hold", {3'd0, word}, {3'd0, stall_word});
        if (valid_o && ready_i) begin
          hs_cnt++;
          if (sb.size() == 0) check_eq("extra_beat", {3'd0, word}, 0);
          else check_eq("beat", {3'd0, word}, {3'd0, sb.pop_front()});
        end
        stall_q = valid_o && !ready_i;
        stall_word = word;
      end
    end
  end

  // VGA monitor: checkerboard spot checks at chosen raster positions
  initial begin
    logic [28:0] w;
    forever begin
      @(negedge clk);
      if (rst_ni && v_valid && v_ready) begin
        w = {v_valid, v_sof, v_vde, v_hsync, v_vsync, v_r, v_g, v_b};
        case (vidx)
          0:     begin check_eq("vga_0_0",   {3'd0, w}, {3'd0, 1'b1, 1'b1, 1'b1, 2'b00, 24'hFFFFFF}); vga_hits++; end
          32:    begin check_eq("vga_32_0",  {3'd0, w}, {3'd0, 1'b1, 1'b0, 1'b1, 2'b00, 24'h000000}); vga_hits++; end
          639:   begin check_eq("vga_639_0", {3'd0, w}, {3'd0, 1'b1, 1'b0, 1'b1, 2'b00, 24'h000000}); vga_hits++; end
          700:   begin check_eq("vga_700_0", {3'd0, w}, {3'd0, 1'b1, 1'b0, 1'b0, 2'b10, 24'h000000}); vga_hits++; end
          25600: begin check_eq("vga_0_32",  {3'd0, w}, {3'd0, 1'b1, 1'b0, 1'b1, 2'b00, 24'h000000}); vga_hits++; end
          25632: begin check_eq("vga_32_32", {3'd0, w}, {3'd0, 1'b1, 1'b0, 1'b1, 2'b00, 24'hFFFFFF}); vga_hits++; end
          default: ;
        endcase
        vidx++;
      end
    end
  end

  initial begin
    #3;
    check_eq("reset_outputs", {20'd0, valid_o, sof_o, vde_o, hsync_o, vsync_o, r_o | g_o | b_o}, 0);
    step();
    rst_ni = 1'b1;
    repeat (10) step();
    check_eq("idle_no_enable", {31'd0, valid_o}, 0);

    // pattern 0 with ready held, enable dropped at beat (3,1)
    hs0 = hs_cnt;
    push_frame(0, 24'h0);
    step();
    enable_i = 1'b1;
    repeat (18) step();
    enable_i = 1'b0;
    drain(300);
    check_eq("frame_beats", hs_cnt - hs0, 98);
    repeat (5) step();
    check_eq("stay_idle", {31'd0, valid_o}, 0);

    // same frame under random backpressure
    hs0 = hs_cnt;
    push_frame(0, 24'h0);
    rand_rdy = 1'b1;
    step();
    enable_i = 1'b1;
    repeat (40) step();
    enable_i = 1'b0;
    drain(2000);
    rand_rdy = 1'b0;
    ready_i = 1'b1;
    check_eq("bp_frame_beats", hs_cnt - hs0, 98);

    // latching and back-to-back frames: solid then gradient
    hs0 = hs_cnt;
    push_frame(3, 24'h123456);
    push_frame(1, 24'h0);
    pattern_i = 2'd3;
    color_i = 24'h123456;
    step();
    enable_i = 1'b1;
    for (int i = 0; i < 196; i++) begin
      step();
      if (i == 19) begin
        pattern_i = 2'd1;
        color_i = 24'hABCDEF;
      end
      if (i == 150) enable_i = 1'b0;
    end
    @(negedge clk);
    #1;
    check_eq("no_bubble_beats", hs_cnt - hs0, 196);
    drain(300);

    // default VGA raster checkerboard
    step();
    v_enable = 1'b1;
    repeat (25640) step();
    v_enable = 1'b0;
    check_eq("vga_hits", vga_hits, 6);

    // reset mid-stream
    pattern_i = 2'd0;
    push_frame(0, 24'h0);
    step();
    enable_i = 1'b1;
    repeat (30) step();
    sb.delete();
    rst_ni = 1'b0;
    enable_i = 1'b0;
    #2;
    check_eq("rst_async", {20'd0, valid_o, sof_o, vde_o, hsync_o, vsync_o, r_o | g_o | b_o}, 0);
    check_eq("rst_async_vga", {31'd0, v_valid}, 0);
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("post_rst_idle", {31'd0, valid_o}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_pattern_gen.md
Name: rgb_pattern_gen

Overview:
Video stream source that produces one RGB pixel beat per timing position, including blanking, with hsync/vsync/vde and a valid/ready handshake. It is the transmitter for the RGB processing chain and feeds its r/g/b, hsync, vsync, vde and valid inputs while honouring its ready output. It runs complete frames of a configurable raster and selects one of four test patterns per frame.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (beats)
H_SYNC, 96, horizontal sync width (beats)
H_BP, 48, horizontal back porch (beats)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
enable_i  in  1  request frame generation; sampled only at frame boundaries
pattern_i  in  2  pattern select; latched at frame start
color_i  in  24  solid colour {r,g,b}; latched at frame start
r_o  out  8  red
g_o  out  8  green
b_o  out  8  blue
hsync_o  out  1  horizontal sync, active-high
vsync_o  out  1  vertical sync, active-high
vde_o  out  1  active video
valid_o  out  1  beat valid
ready_i  in  1  downstream ready
sof_o  out  1  high with beat (0,0) of each frame

Behaviour:
- One clock (clk_i); reset is asynchronous and active-low (rst_ni). All outputs are registered.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Counter widths are $clog2(H_TOTAL) and $clog2(V_TOTAL). BAR_W = H_ACTIVE/8.
- Reset state: IDLE. h_cnt = v_cnt = 0. All outputs are 0. Reset mid-frame aborts immediately, with no completion of the frame.
- FSM states are IDLE and RUN.
  - IDLE -> RUN on a clock edge where enable_i=1. In the next cycle valid_o=1 with beat (h=0, v=0) and sof_o=1. pattern_i and color_i are latched on that edge.
  - In RUN, valid_o stays 1 continuously. The counters advance only on a handshake (valid_o & ready_i).
  - h wraps H_TOTAL-1 -> 0 with v+1. At the handshake of beat (H_TOTAL-1, V_TOTAL-1):
    - if enable_i=1: next beat is (0,0) with no bubble, and pattern/colour are re-latched;
    - else: valid_o=0 on the next cycle and the FSM goes to IDLE.
  - enable_i deasserted mid-frame is ignored until the frame ends.
- Backpressure: while valid_o=1 and ready_i=0, every output holds stable, with no skipped or repeated beats. ready_i is ignored in IDLE.
- Beat fields for position (h, v):
  - vde = (h < H_ACTIVE) & (v < V_ACTIVE)
  - hsync = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vsync = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for all h of those lines
  - r = g = b = 0 whenever vde = 0
- Patterns (apply when vde=1):
  - 0 colour bars: bar index idx (0..7) comes from a pixel-in-bar counter, increments every BAR_W active pixels, saturates at 7, and resets each line. r = {8{~idx[1]}}, g = {8{~idx[2]}}, b = {8{~idx[0]}}. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - 1 gradient: r = g = b = h[7:0] (wraps every 256).
  - 2 checkerboard: r = g = b = (h[5]^v[5]) ? 8'h00 : 8'hFF (32x32 squares).
  - 3 solid: {r,g,b} = latched color_i.

Decomposition:
- Package rgb_pattern_pkg holds:
  - pattern_e enum (PAT_BARS=0, PAT_GRAD=1, PAT_CHECK=2, PAT_SOLID=3);
  - state_e enum (IDLE, RUN);
  - the default VGA timing constants.
- One sub-module, video_timing_counter: parameterised h/v counters with an advance input, a frame-end flag, and registered hsync/vsync/vde. rgb_pattern_gen holds the FSM, the latches and the pixel generation.

Test Plan:
- Reset: assert rst_ni=0 mid-stream -> all outputs 0 asynchronously; after release with enable_i=0 -> valid_o stays 0 forever.
- Small raster (H 8/2/2/2, V 4/1/1/1, BAR_W=1), ready_i=1, pattern 0 -> 98 consecutive beats with sof_o only on beat 0.
  - Line 0 RGB sequence: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - hsync high at h=10,11.
  - vsync high for all of line 5.
  - vde high only for h<8, v<4.
- Backpressure: random ready_i (50%) -> sequence captured on handshakes is identical to the ready_i=1 run, and outputs are stable during every stall.
- Frame boundary: drop enable_i at beat (3,1) -> frame completes all 98 beats, then valid_o=0. Keep enable_i=1 -> beat (0,0) follows (13,6) with no idle cycle.
- Latching: pattern_i=3, color_i=24'h123456 at start; change to pattern 1 mid-frame -> the whole frame is 12/34/56 on active pixels, and the next frame is a gradient (r=g=b=h).
- Checkerboard at default VGA: pattern 2 -> pixel (0,0)=FF, (32,0)=00, (32,32)=FF, and blanking beats are 0.
